// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file widths, sizes and types
package rf_pkg;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int NREGS = 12;
  typedef logic [AW-1:0] rf_adr_t;
  typedef logic [DW-1:0] rf_data_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: N-way round-robin one-hot grant; pointer moves past each winner
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_gnt
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_win;
  logic [PW:0]   w_s;
  logic          w_any;
  // scan from the pointer, highest offset first, so the nearest requester is the last (winning) write
  always_comb begin
    o_gnt = '0;
    w_win = r_ptr;
    w_any = 1'b0;
    w_s   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_s = {1'b0, r_ptr} + (PW + 1)'(k);
      w_s = (w_s >= (PW + 1)'(N)) ? w_s - (PW + 1)'(N) : w_s;
      if (i_req[w_s[PW-1:0]]) begin
        o_gnt = '0;
        o_gnt[w_s[PW-1:0]] = 1'b1;
        w_win = w_s[PW-1:0];
        w_any = 1'b1;
      end
    end
  end
  // pointer moves one past the winner, holds when nothing is granted
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_ptr <= '0;
    else if (w_any) r_ptr <= (w_win == PW'(N - 1)) ? '0 : w_win + 1'b1;
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin share of the RF write port plus busy-bit scoreboard (RF_WB_FWD_EN adds bypass outputs)
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*AW-1:0] req_adr,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic               alloc_valid,
  input  rf_adr_t            alloc_adr,
  output logic               alloc_ready,
  input  rf_adr_t            chk_a1,
  input  rf_adr_t            chk_a2,
  output logic               busy1,
  output logic               busy2,
  output logic               rf_we,
  output rf_adr_t            rf_adr,
  output rf_data_t           rf_data,
`ifdef RF_WB_FWD_EN
  output logic               fwd1,
  output logic               fwd2,
  output rf_data_t           fwd_data,
`endif
  output logic               adr_err
);
  localparam int NA = 1 << AW;
  localparam logic [AW:0] LIM = (AW + 1)'(NREGS);
  logic [NREQ-1:0]  w_gnt;
  rf_adr_t          w_adr;
  rf_data_t         w_data;
  logic             w_any;
  logic             w_ok;
  logic             r_we;
  rf_adr_t          r_adr;
  rf_data_t         r_data;
  logic             r_err;
  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_set;
  logic [NREGS-1:0] w_clr;
  logic [NA-1:0]    w_busy_x;
  logic             w_alloc_ok;
  rr_arbiter #(.N(NREQ)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .i_req (req_valid),
    .o_gnt (w_gnt)
  );
  assign req_ready = w_gnt;
  assign w_any     = |w_gnt;
  // select the granted requester's address and data
  always_comb begin
    w_adr  = '0;
    w_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_adr  = w_gnt[i] ? req_adr[i*AW +: AW]  : w_adr;
      w_data = w_gnt[i] ? req_data[i*DW +: DW] : w_data;
    end
  end
  assign w_ok = {1'b0, w_adr} < LIM;
  // registered write port; out-of-range grants are consumed without a write and flag the sticky error
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_we   <= 1'b0;
      r_adr  <= '0;
      r_data <= '0;
      r_err  <= 1'b0;
    end else begin
      r_we  <= w_any & w_ok;
      r_err <= r_err | (w_any & ~w_ok);
      if (w_any & w_ok) begin
        r_adr  <= w_adr;
        r_data <= w_data;
      end
    end
  assign rf_we   = r_we;
  assign rf_adr  = r_adr;
  assign rf_data = r_data;
  assign adr_err = r_err;
  assign w_busy_x    = NA'(r_busy);
  assign w_alloc_ok  = alloc_valid & ~w_busy_x[alloc_adr] & ({1'b0, alloc_adr} < LIM);
  assign alloc_ready = w_alloc_ok;
  for (genvar g = 0; g < NREGS; g++) begin : g_sb
    assign w_set[g] = w_alloc_ok & (alloc_adr == AW'(g));
    assign w_clr[g] = r_we & (r_adr == AW'(g));
  end
  // scoreboard: set on accepted alloc, clear on write; set wins on the same bit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_busy <= '0;
    else r_busy <= (r_busy & ~w_clr) | w_set;
`ifdef RF_WB_FWD_EN
  assign fwd1     = r_we & (r_adr == chk_a1);
  assign fwd2     = r_we & (r_adr == chk_a2);
  assign fwd_data = r_data;
  assign busy1    = w_busy_x[chk_a1] & ~fwd1;
  assign busy2    = w_busy_x[chk_a2] & ~fwd2;
`else
  assign busy1 = w_busy_x[chk_a1];
  assign busy2 = w_busy_x[chk_a2];
`endif
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Shares the register file's single write port (we / data_adr / data_in) between NREQ writeback requesters, e.g. ALU and load unit. Arbitration is round-robin. The write-port outputs are registered.
A busy-bit scoreboard tracks destination registers that have been allocated but not yet written. Issue logic uses it to stall read-after-write and write-after-write hazards.
Sits between the execute/memory stages and register_file, and drives its write port exclusively.

Parameters:
NREQ, 2, number of writeback requesters (2..4)
NREGS, 12, number of implemented registers
AW, 5, register address width
DW, 32, data width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NREQ  writeback request per requester
req_ready  output  NREQ  grant; transfer when valid & ready
req_adr  input  NREQ*AW  destination address, requester i at [i*AW +: AW]
req_data  input  NREQ*DW  write data, requester i at [i*DW +: DW]
alloc_valid  input  1  issue stage claims a destination register
alloc_adr  input  AW  register being claimed
alloc_ready  output  1  claim accepted this cycle
chk_a1  input  AW  read address 1 to hazard-check
chk_a2  input  AW  read address 2 to hazard-check
busy1  output  1  chk_a1 has a pending write
busy2  output  1  chk_a2 has a pending write
rf_we  output  1  to register_file we
rf_adr  output  AW  to register_file data_adr
rf_data  output  DW  to register_file data_in
adr_err  output  1  sticky: out-of-range address seen

Behaviour:
- Reset (async assert, sync release): rf_we=0, rf_adr=0, rf_data=0, adr_err=0, all busy bits 0, round-robin pointer=0.
- Arbitration (combinational):
  - At most one req_ready bit high per cycle.
  - Search starts at pointer and wraps modulo NREQ; the first valid requester wins.
  - req_ready[i] is never high unless req_valid[i] is high.
- Write-port timing:
  - A grant in cycle N produces rf_we=1 in cycle N+1, with rf_adr/rf_data captured from the winner. Latency is 1.
  - No grant in a cycle gives rf_we=0 in the next cycle; rf_adr/rf_data hold their last values.
  - Throughput is one write per cycle.
- Round-robin pointer: after a grant to requester i, pointer becomes (i+1) mod NREQ. Without a grant it holds.
- Out-of-range address (req_adr >= NREGS): the request is still granted, rf_we stays 0 for that slot, and adr_err sets and stays set until reset.
- Scoreboard:
  - NREGS busy bits.
  - alloc_ready = alloc_valid & ~busy[alloc_adr] & (alloc_adr < NREGS).
  - An accepted alloc sets busy[alloc_adr] at the next edge.
  - Each edge where rf_we=1 clears busy[rf_adr].
  - If a set and a clear hit the same address on the same edge, the set wins.
- Hazard outputs:
  - busy1 = busy[chk_a1]; busy2 = busy[chk_a2]. Both are combinational from current state.
  - Out-of-range check addresses report 0.
- Writes without a prior alloc are legal. The clear of an already-clear bit is a no-op.
- Reset mid-operation: a pending rf_we is dropped and all busy bits clear; requesters must re-present.

Optional Feature:
RF_WB_FWD_EN
- Defined:
  - Extra outputs fwd1/fwd2 (1 bit) and fwd_data (DW) are present.
  - fwd1 = rf_we & (rf_adr == chk_a1); fwd2 is the same against chk_a2. fwd_data = rf_data.
  - busy1/busy2 are forced to 0 when the corresponding fwd bit is 1, allowing same-cycle bypass.
- Not defined: those ports are absent; busy1/busy2 behave as above.

Decomposition:
- Package rf_pkg holds: AW, DW, NREGS constants; typedef rf_adr_t (logic [AW-1:0]); typedef rf_data_t (logic [DW-1:0]).
- One sub-module: rr_arbiter (NREQ-wide round-robin grant with pointer update), reusable elsewhere.
- The scoreboard stays inline.

Test Plan:
- Reset, then idle: rf_we=0, busy1=busy2=0, adr_err=0, alloc_ready=1 for alloc_adr=3.
- Requester 0 only, adr=5, data=0xA5 -> req_ready=01. Next cycle: rf_we=1, rf_adr=5, rf_data=0x000000A5.
- Both valid for 4 cycles (adr 1 and 2) -> grants alternate 01,10,01,10. rf_adr sequence 1,2,1,2, one cycle delayed.
- Alloc adr 7 -> busy checks:
  - With chk_a1=7: busy1=1; a second alloc of 7 gives alloc_ready=0.
  - After a writeback to 7: busy1=0 the cycle after rf_we.
  - Same-edge alloc 7 plus rf_we to 7 leaves busy[7]=1.
- Request with adr=12 (>= NREGS) -> granted; rf_we stays 0; adr_err=1 and persists.
- rst_n pulsed low while rf_we=1 and busy[4]=1 -> rf_we=0 and busy[4]=0 immediately, without waiting for a clock edge.
